motor_cmd_sequencer: RTL and testbench
======================================

# motor_cmd_sequencer

Command sequencer between the SPI word receiver and the motor/encoder/spectrometer datapath. It synchronises the SPI `data_ready` strobe into the GCLK domain and decodes each 32-bit command word. It writes per-channel PWM period/uptime through shadow registers that commit only at PWM cycle boundaries, issues encoder reset pulses, and drives the readback select and spectrometer bin address. It replaces the ad-hoc load logic in the top level.

## Interface
Parameters:
- `NUM_GPIO`, 3: PWM channels.
- `NUM_ENCODERS`, 3: encoder channels.
- `NUM_BINS`, 640: spectrometer bins; `bin_addr` wraps at `NUM_BINS-1`.
- `PWM_W`, 21: period/uptime width.
- `SYNC_STAGES`, 2: `data_ready` synchroniser depth (≥2).
- `RESET_PERIOD`, 20000: period reset value, in 1 µs units.
- `WDT_CYCLES`, 50_000_000: watchdog timeout in GCLK cycles (only with the macro).

Ports:
- `GCLK` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `spi_data_in` in 32: received word, asynchronous to GCLK.
- `spi_data_ready` in 1: asynchronous, high while `spi_data_in` is valid.
- `pwm_cycle_end` in NUM_GPIO: 1-cycle strobe per channel at PWM period wrap, GCLK domain.
- `motor_periods` out NUM_GPIO×PWM_W: active periods.
- `motor_uptimes` out NUM_GPIO×PWM_W: active uptimes.
- `enc_reset` out NUM_ENCODERS: 1-cycle reset pulses.
- `read_sel` out 8: readback mux select.
- `bin_addr` out 10: spectrometer bin address.
- `cmd_error` out 1: sticky; cleared only by reset.
- `cmd_count` out 16: count of accepted commands, wraps.

## Operation
- Field decode: cmd=[31:26], idx=[25:21], value=[20:0], addr=[7:0].
- Commands:
  - 0 = set uptime.
  - 1 = select readback.
  - 2 = set period.
  - 3 = reset encoder.
  - Any other cmd value sets `cmd_error`; no other effect.
- FSM states and transitions:
  - IDLE → CAPTURE on the rising edge of the synchronised ready.
  - CAPTURE latches `spi_data_in` → EXEC.
  - EXEC applies the command → IDLE.
  - Exactly one command executes per `data_ready` rising edge.
- Set period / set uptime:
  - Writes the shadow register for channel idx and sets `pending[idx]`.
  - If idx ≥ NUM_GPIO: sets `cmd_error`, command is ignored.
- Commit:
  - On `pwm_cycle_end[i]` with `pending[i]`, both shadows copy to the active registers in one cycle; `pending[i]` clears.
  - If shadow uptime > shadow period at commit, active uptime = active period (clamp) and `cmd_error` is set.
- Reset encoder:
  - `enc_reset[idx]` goes high for exactly one cycle.
  - If idx ≥ NUM_ENCODERS: sets `cmd_error`, no pulse.
- Select readback:
  - If addr = 2 and `read_sel` already = 2: `bin_addr` increments, NUM_BINS-1 wraps to 0.
  - If addr = 2 and `read_sel` ≠ 2: `bin_addr` = 0 and `read_sel` = 2.
  - Any other addr: `read_sel` = addr; `bin_addr` unchanged.
- `cmd_count` increments on every EXEC that does not set `cmd_error`.

## Timing
- Reset values:
  - `motor_periods` = RESET_PERIOD; `motor_uptimes` = 0; shadows equal the active registers.
  - `pending` = 0, `enc_reset` = 0, `read_sel` = 0, `bin_addr` = 0, `cmd_error` = 0, `cmd_count` = 0.
  - FSM = IDLE.
- Latency:
  - Ready edge at the synchroniser input → CAPTURE: SYNC_STAGES+1 cycles.
  - EXEC effect visible on outputs one cycle after CAPTURE.
- `spi_data_in` is held stable by the SPI block for ≥ SYNC_STAGES+3 GCLK cycles after `data_ready` rises.
- `data_ready` held high longer than that triggers no second command; a new edge requires a low phase of ≥ SYNC_STAGES cycles.
- Simultaneous EXEC write and `pwm_cycle_end` on the same channel:
  - The commit uses the pre-write shadow.
  - The new value stays pending for the next cycle end.
- Reset mid-command: the in-flight word is discarded and all state returns to reset values on the next cycle.

## Configuration
- `CMD_WATCHDOG_EN` defined:
  - A counter clears on every accepted command.
  - On reaching WDT_CYCLES, all active and shadow uptimes are forced to 0, pending clears, and `cmd_error` is set.
  - Periods are untouched.
  - The counter saturates until the next accepted command.
- Undefined: no counter; outputs hold indefinitely.

## Structure
- Package `motor_cmd_pkg`:
  - enum `cmd_t` (CMD_SET_UPTIME = 0, CMD_SEND_DATA = 1, CMD_SET_PERIOD = 2, CMD_RESET_ENC = 3).
  - Field bit-position localparams.
  - FSM state enum.
  - `READ_SEL_BINS` = 2.
- Sub-module `pulse_sync` (SYNC_STAGES flop chain plus rising-edge detect) handles `spi_data_ready`.
- The per-channel shadow/commit logic lives in a generate loop in the top module, not a separate module.

## Test plan
- Reset, then word 0x0820_1388 (period 5000, ch1), then `pwm_cycle_end[1]`:
  - `motor_periods[1]` stays 20000 until the strobe, then becomes 5000.
  - `cmd_count` = 1.
- Period 1000 then uptime 1500 on ch0, then cycle end:
  - Active uptime = 1000 (clamped).
  - `cmd_error` = 1.
- Word 0x0C40_0000 (reset enc ch2):
  - `enc_reset` = 3'b100 for one cycle, exactly SYNC_STAGES+2 cycles after the ready edge.
- Send_data addr 2 issued 641 times:
  - `read_sel` = 2.
  - `bin_addr` = 0 after the 1st, 639 after the 640th, 0 after the 641st.
- Uptime write to ch0 in the same cycle as `pwm_cycle_end[0]` with an older value pending:
  - The old value commits.
  - The new value commits on the next strobe.
- Cmd 7, idx 31 on a period write, and `data_ready` held high 100 cycles:
  - `cmd_error` set by cmd 7 and by the idx-31 write.
  - The held-high ready executes only one command.
  - With `CMD_WATCHDOG_EN` and WDT_CYCLES = 100: uptimes become 0 after 100 idle cycles.

Source files
------------

// File: rtl/motor_cmd_pkg.sv
// Shared encodings for the motor command sequencer: command opcodes, word field
// positions, FSM states and the readback select that steps the spectrometer bins.
package motor_cmd_pkg;

    typedef enum logic [5:0] {
        CMD_SET_UPTIME = 6'd0,
        CMD_SEND_DATA  = 6'd1,
        CMD_SET_PERIOD = 6'd2,
        CMD_RESET_ENC  = 6'd3
    } cmd_t;

    localparam int CMD_HI  = 31;
    localparam int CMD_LO  = 26;
    localparam int IDX_HI  = 25;
    localparam int IDX_LO  = 21;
    localparam int VAL_HI  = 20;
    localparam int VAL_LO  = 0;
    localparam int ADDR_HI = 7;
    localparam int ADDR_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_EXEC
    } state_t;

    localparam logic [7:0] READ_SEL_BINS = 8'd2;

endpackage

// File: rtl/motor_cmd_sequencer_pulse_sync.sv
// Brings an asynchronous level into the local clock domain through a flop chain
// and emits a one-cycle pulse on its synchronised rising edge.
module pulse_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              last_q, last_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        last_d = sync_q[STAGES-1];
        rise   = sync_q[STAGES-1] & ~last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Decodes SPI command words into PWM shadow writes, encoder resets and readback
// selection. Optional CMD_WATCHDOG_EN zeroes all uptimes after a command drought.
module motor_cmd_sequencer
    import motor_cmd_pkg::*;
#(
    parameter int NUM_GPIO     = 3,
    parameter int NUM_ENCODERS = 3,
    parameter int NUM_BINS     = 640,
    parameter int PWM_W        = 21,
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_PERIOD = 20000,
    parameter int WDT_CYCLES   = 50_000_000
) (
    input  logic                      GCLK,
    input  logic                      reset,
    input  logic [31:0]               spi_data_in,
    input  logic                      spi_data_ready,
    input  logic [NUM_GPIO-1:0]       pwm_cycle_end,
    output logic [NUM_GPIO*PWM_W-1:0] motor_periods,
    output logic [NUM_GPIO*PWM_W-1:0] motor_uptimes,
    output logic [NUM_ENCODERS-1:0]   enc_reset,
    output logic [7:0]                read_sel,
    output logic [9:0]                bin_addr,
    output logic                      cmd_error,
    output logic [15:0]               cmd_count
);

    state_t                  state_q, state_d;
    logic [31:0]             word_q, word_d;
    logic                    rdy_rise;
    cmd_t                    cmd_f;
    logic [4:0]              idx_f;
    logic [PWM_W-1:0]        wr_val;
    logic [7:0]              addr_f;
    logic [NUM_GPIO-1:0]     wr_per, wr_up, clamp_err;
    logic [NUM_ENCODERS-1:0] enc_pulse;
    logic                    cmd_err_c, accepted, wdt_fire;
    logic [7:0]              read_sel_q, read_sel_d;
    logic [9:0]              bin_q, bin_d;
    logic                    err_q, err_d;
    logic [15:0]             count_q, count_d;

    pulse_sync #(.STAGES(SYNC_STAGES)) u_rdy_sync (
        .clk      (GCLK),
        .reset    (reset),
        .async_in (spi_data_ready),
        .rise     (rdy_rise)
    );

    assign cmd_f  = cmd_t'(word_q[CMD_HI:CMD_LO]);
    assign idx_f  = word_q[IDX_HI:IDX_LO];
    assign wr_val = PWM_W'(word_q[VAL_HI:VAL_LO]);
    assign addr_f = word_q[ADDR_HI:ADDR_LO];

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE:    if (rdy_rise) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                word_d  = spi_data_in;
                state_d = ST_EXEC;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Command decode is only live in EXEC, so every strobe below lasts one cycle.
    always_comb begin
        wr_per    = '0;
        wr_up     = '0;
        enc_pulse = '0;
        cmd_err_c = 1'b0;
        if (state_q == ST_EXEC) begin
            case (cmd_f)
                CMD_SET_UPTIME, CMD_SET_PERIOD: begin
                    for (int i = 0; i < NUM_GPIO; i++) begin
                        if (idx_f == 5'(i)) begin
                            if (cmd_f == CMD_SET_PERIOD) wr_per[i] = 1'b1;
                            else                         wr_up[i]  = 1'b1;
                        end
                    end
                    cmd_err_c = ~|(wr_per | wr_up);
                end
                CMD_RESET_ENC: begin
                    for (int i = 0; i < NUM_ENCODERS; i++)
                        if (idx_f == 5'(i)) enc_pulse[i] = 1'b1;
                    cmd_err_c = ~|enc_pulse;
                end
                CMD_SEND_DATA: cmd_err_c = 1'b0;
                default:       cmd_err_c = 1'b1;
            endcase
        end
    end

    assign accepted  = (state_q == ST_EXEC) & ~cmd_err_c;
    assign enc_reset = enc_pulse;

    always_comb begin
        read_sel_d = read_sel_q;
        bin_d      = bin_q;
        if (state_q == ST_EXEC && cmd_f == CMD_SEND_DATA) begin
            if (addr_f == READ_SEL_BINS) begin
                if (read_sel_q == READ_SEL_BINS)
                    bin_d = (bin_q == 10'(NUM_BINS - 1)) ? 10'd0 : bin_q + 10'd1;
                else
                    bin_d = 10'd0;
            end
            read_sel_d = addr_f;
        end
        err_d   = err_q | cmd_err_c | (|clamp_err) | wdt_fire;
        count_d = count_q + 16'(accepted);
    end

    always_ff @(posedge GCLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            read_sel_q <= '0;
            bin_q      <= '0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            read_sel_q <= read_sel_d;
            bin_q      <= bin_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign read_sel  = read_sel_q;
    assign bin_addr  = bin_q;
    assign cmd_error = err_q;
    assign cmd_count = count_q;

`ifdef CMD_WATCHDOG_EN
    logic [31:0] wdt_q, wdt_d;

    always_comb begin
        wdt_d    = wdt_q;
        wdt_fire = 1'b0;
        if (accepted) begin
            wdt_d = '0;
        end else if (wdt_q < 32'(WDT_CYCLES)) begin
            wdt_d    = wdt_q + 32'd1;
            wdt_fire = (wdt_q == 32'(WDT_CYCLES - 1));
        end
    end

    always_ff @(posedge GCLK) begin
        if (reset) wdt_q <= '0;
        else       wdt_q <= wdt_d;
    end
`else
    // Keeps the timeout parameter referenced when the watchdog is compiled out.
    logic wdt_unused;
    assign wdt_unused = (WDT_CYCLES != 0);
    assign wdt_fire   = 1'b0;
`endif

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_ch
        logic [PWM_W-1:0] sh_per_q, sh_per_d, sh_up_q, sh_up_d;
        logic [PWM_W-1:0] per_q, per_d, up_q, up_d;
        logic             pend_q, pend_d, clamp_c;

        // Commit reads the pre-write shadows; a same-cycle write re-arms pending.
        always_comb begin
            sh_per_d = sh_per_q;
            sh_up_d  = sh_up_q;
            per_d    = per_q;
            up_d     = up_q;
            pend_d   = pend_q;
            clamp_c  = 1'b0;
            if (pwm_cycle_end[g] && pend_q) begin
                per_d  = sh_per_q;
                pend_d = 1'b0;
                if (sh_up_q > sh_per_q) begin
                    up_d    = sh_per_q;
                    clamp_c = 1'b1;
                end else begin
                    up_d = sh_up_q;
                end
            end
            if (wr_per[g]) begin
                sh_per_d = wr_val;
                pend_d   = 1'b1;
            end
            if (wr_up[g]) begin
                sh_up_d = wr_val;
                pend_d  = 1'b1;
            end
            if (wdt_fire) begin
                sh_up_d = '0;
                up_d    = '0;
                pend_d  = 1'b0;
            end
        end

        always_ff @(posedge GCLK) begin
            if (reset) begin
                sh_per_q <= PWM_W'(RESET_PERIOD);
                per_q    <= PWM_W'(RESET_PERIOD);
                sh_up_q  <= '0;
                up_q     <= '0;
                pend_q   <= 1'b0;
            end else begin
                sh_per_q <= sh_per_d;
                per_q    <= per_d;
                sh_up_q  <= sh_up_d;
                up_q     <= up_d;
                pend_q   <= pend_d;
            end
        end

        assign clamp_err[g]                    = clamp_c;
        assign motor_periods[g*PWM_W +: PWM_W] = per_q;
        assign motor_uptimes[g*PWM_W +: PWM_W] = up_q;
    end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Scoreboard bench for motor_cmd_sequencer: stimulus tasks update a behavioural
// model and queue expected snapshots; a negedge monitor pops and compares them.
module tb_motor_cmd_sequencer;

    localparam int S  = 2;
    localparam int NG = 3;
    localparam int W  = 21;

    logic             GCLK = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      spi_data_in = '0;
    logic             spi_data_ready = 1'b0;
    logic [NG-1:0]    pwm_cycle_end = '0;
    logic [NG*W-1:0]  motor_periods, motor_uptimes;
    logic [2:0]       enc_reset;
    logic [7:0]       read_sel;
    logic [9:0]       bin_addr;
    logic             cmd_error;
    logic [15:0]      cmd_count;

    motor_cmd_sequencer dut (
        .GCLK           (GCLK),
        .reset          (reset),
        .spi_data_in    (spi_data_in),
        .spi_data_ready (spi_data_ready),
        .pwm_cycle_end  (pwm_cycle_end),
        .motor_periods  (motor_periods),
        .motor_uptimes  (motor_uptimes),
        .enc_reset      (enc_reset),
        .read_sel       (read_sel),
        .bin_addr       (bin_addr),
        .cmd_error      (cmd_error),
        .cmd_count      (cmd_count)
    );

    always #5 GCLK = ~GCLK;

    int cyc = 0;
    always @(posedge GCLK) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          is_enc;
        logic [2:0]  enc;
        logic [7:0]  rs;
        logic [9:0]  bin;
        logic        err;
        logic [15:0] cnt;
        logic [NG*W-1:0] per;
        logic [NG*W-1:0] up;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [W-1:0] m_sh_per[NG], m_sh_up[NG], m_per[NG], m_up[NG];
    bit           m_pend[NG];
    logic [7:0]   m_rs;
    logic [9:0]   m_bin;
    logic         m_err;
    logic [15:0]  m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NG; i++) begin
            m_sh_per[i] = 21'd20000; m_per[i] = 21'd20000;
            m_sh_up[i]  = '0;        m_up[i]  = '0;
            m_pend[i]   = 0;
        end
        m_rs = '0; m_bin = '0; m_err = 0; m_cnt = '0;
    endtask

    task automatic model_commit(input logic [NG-1:0] mask);
        for (int i = 0; i < NG; i++) begin
            if (mask[i] && m_pend[i]) begin
                m_per[i] = m_sh_per[i];
                if (m_sh_up[i] > m_sh_per[i]) begin
                    m_up[i] = m_sh_per[i];
                    m_err   = 1;
                end else begin
                    m_up[i] = m_sh_up[i];
                end
                m_pend[i] = 0;
            end
        end
    endtask

    task automatic model_cmd(input logic [31:0] w);
        int idx, c;
        bit bad;
        c   = int'(w[31:26]);
        idx = int'(w[25:21]);
        bad = 0;
        case (c)
            0, 2: if (idx < NG) begin
                      if (c == 2) m_sh_per[idx] = w[20:0];
                      else        m_sh_up[idx]  = w[20:0];
                      m_pend[idx] = 1;
                  end else bad = 1;
            1: if (w[7:0] == 8'd2) begin
                   if (m_rs == 8'd2) m_bin = (m_bin == 10'd639) ? 10'd0 : m_bin + 10'd1;
                   else begin m_bin = 10'd0; m_rs = 8'd2; end
               end else m_rs = w[7:0];
            3: if (idx >= 3) bad = 1;
            default: bad = 1;
        endcase
        if (bad) m_err = 1;
        else     m_cnt = m_cnt + 16'd1;
    endtask

    task automatic push_snap(input int due);
        exp_t e;
        e.due = due; e.is_enc = 0; e.enc = '0;
        e.rs = m_rs; e.bin = m_bin; e.err = m_err; e.cnt = m_cnt;
        for (int i = 0; i < NG; i++) begin
            e.per[i*W +: W] = m_per[i];
            e.up[i*W +: W]  = m_up[i];
        end
        sb.push_back(e);
    endtask

    task automatic push_enc(input int due, input logic [2:0] pulse);
        exp_t e;
        e.due = due; e.is_enc = 1; e.enc = pulse;
        e.rs = '0; e.bin = '0; e.err = 0; e.cnt = '0; e.per = '0; e.up = '0;
        sb.push_back(e);
    endtask

    // Issue one command; ce is driven in the cycle the command executes.
    task automatic send(input logic [31:0] w, input logic [NG-1:0] ce, input int extra);
        int n;
        @(negedge GCLK);
        spi_data_in = w; spi_data_ready = 1'b1; n = cyc;
        if (w[31:26] == 6'd3 && w[25:21] < 5'd3) push_enc(n + S + 2, 3'b001 << w[25:21]);
        repeat (S + 2) @(negedge GCLK);
        pwm_cycle_end = ce;
        model_commit(ce);
        model_cmd(w);
        push_snap(n + S + 3);
        @(negedge GCLK);
        pwm_cycle_end = '0;
        repeat (extra) @(negedge GCLK);
        spi_data_ready = 1'b0; spi_data_in = $urandom;
        repeat (S + 1) @(negedge GCLK);
    endtask

    task automatic cycle_end(input logic [NG-1:0] mask);
        @(negedge GCLK);
        pwm_cycle_end = mask;
        model_commit(mask);
        push_snap(cyc + 1);
        @(negedge GCLK);
        pwm_cycle_end = '0;
    endtask

    task automatic snap();
        push_snap(cyc + 1);
        @(negedge GCLK);
    endtask

    task automatic do_reset();
        @(negedge GCLK);
        reset = 1'b1; spi_data_ready = 1'b0; pwm_cycle_end = '0;
        repeat (2) @(negedge GCLK);
        reset = 1'b0;
        model_reset();
        snap();
    endtask

    function automatic logic [31:0] mk(input int c, input int idx, input int val);
        return {6'(c), 5'(idx), 21'(val)};
    endfunction

    always @(negedge GCLK) begin
        logic [2:0] exp_enc;
        exp_t e;
        exp_enc = '0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                checks++; errors++;
                $display("FAIL late_expectation: due=%0d now=%0d", e.due, cyc);
            end else if (e.is_enc) begin
                exp_enc |= e.enc;
            end else begin
                chk("read_sel",  64'(read_sel),      64'(e.rs));
                chk("bin_addr",  64'(bin_addr),      64'(e.bin));
                chk("cmd_error", 64'(cmd_error),     64'(e.err));
                chk("cmd_count", 64'(cmd_count),     64'(e.cnt));
                chk("periods",   64'(motor_periods), 64'(e.per));
                chk("uptimes",   64'(motor_uptimes), 64'(e.up));
            end
        end
        if (!reset) chk("enc_reset", 64'(enc_reset), 64'(exp_enc));
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n, r, idx;
        logic [31:0] w;
        model_reset();
        repeat (3) @(negedge GCLK);
        reset = 1'b0;
        snap();

        // Period 5000 on ch1 stays shadowed until its cycle end
        send(32'h0820_1388, '0, 0);
        cycle_end(3'b001);
        cycle_end(3'b010);

        send(32'h0C40_0000, '0, 0);

        // Bin stepping through a full wrap
        send(mk(1, 0, 5), '0, 0);
        for (int i = 0; i < 641; i++) send(mk(1, 0, 2), '0, 0);
        send(mk(1, 0, 9), '0, 0);

        // Write collides with the commit strobe on ch0
        send(mk(0, 0, 100), '0, 0);
        send(mk(0, 0, 200), 3'b001, 0);
        cycle_end(3'b001);

        // Uptime above period clamps at commit
        send(mk(2, 0, 1000), '0, 0);
        send(mk(0, 0, 1500), '0, 0);
        cycle_end(3'b001);

        do_reset();
        send(mk(7, 0, 0), '0, 0);
        do_reset();
        send(mk(2, 31, 1234), '0, 0);
        do_reset();
        send(mk(3, 3, 0), '0, 0);
        do_reset();
        send(mk(1, 0, 5), '0, 100);
        snap();

        // Reset while the word sits in CAPTURE
        @(negedge GCLK);
        spi_data_in = mk(2, 0, 777); spi_data_ready = 1'b1;
        repeat (S + 1) @(negedge GCLK);
        reset = 1'b1; spi_data_ready = 1'b0;
        @(negedge GCLK);
        reset = 1'b0;
        model_reset();
        snap();
        repeat (S + 4) @(negedge GCLK);
        snap();

        for (int k = 0; k < 80; k++) begin
            r   = $urandom_range(0, 9);
            idx = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 3);
            case (r)
                0, 1, 2: w = mk(0, idx, $urandom_range(0, 30000));
                3, 4, 5: w = mk(2, idx, $urandom_range(1000, 40000));
                6:       w = mk(1, 0, $urandom_range(0, 255));
                7:       w = mk(3, idx, 0);
                8:       w = mk($urandom_range(4, 63), idx, $urandom_range(0, 2097151));
                default: w = mk(1, 0, 2);
            endcase
            if ($urandom_range(0, 2) == 0) cycle_end(3'($urandom));
            send(w, ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000, 0);
        end
        cycle_end(3'b111);

        repeat (4) @(negedge GCLK);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: actual=%0d entries required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
